smol_fetch_ctrl: RTL and testbench

//   Instruction-fetch sequencer for the smolCore instruction ROM, instantiated with SYNC_READ=1.
//   - Owns the program counter and drives the ROM byte address.
//   - Tracks the single in-flight read and buffers returned words in a 2-entry FIFO.
//   - Presents {instr, pc} to decode over a valid/ready handshake.
//   - Handles start/halt control and PC redirects (branch/jump/trap) from execute.
//

---
 rtl/smol_pkg.sv | 21 ++
 rtl/smol_fetch_fifo.sv | 47 ++++
 rtl/smol_fetch_ctrl.sv | 97 +++++++++
 tb/tb_smol_fetch_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/smol_pkg.sv
// Shared types for the smolCore fetch path: FSM states, the buffered fetch entry
// and the default reset PC.
package smol_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/smol_fetch_fifo.sv
// Two-entry FIFO holding returned {instr, pc} words for decode.
// Flush clears occupancy and wins over a simultaneous push.
module smol_fetch_fifo
    import smol_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & (count != 2'd0);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage carries no reset; consumers qualify the head with count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(do_push && !do_pop && (count == 2'd2)));

endmodule

// File: rtl/smol_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one synchronous ROM read at a time
// and buffers returned words for decode, with start/halt control and redirects.
module smol_fetch_ctrl
    import smol_pkg::*;
#(
    parameter int unsigned     ADDR_WIDTH = 10,
    parameter int unsigned     DATA_WIDTH = INSTR_W,
    parameter int unsigned     XLEN       = PC_W,
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  halt_req,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic [ADDR_WIDTH+1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [XLEN-1:0]       out_pc,
    output logic                  busy
);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inflight_pc_q;
    logic            inflight_q;
    logic [1:0]      fifo_count;
    fetch_entry_t    fifo_head;
    fetch_entry_t    push_entry;
    logic [2:0]      occupancy;
    logic [XLEN-1:0] redirect_target;
    logic            pop;
    logic            issue;

    assign pop = out_valid & out_ready;

    // Slots already claimed once this cycle's pop and the landing word settle;
    // a new read is only launched if its word is guaranteed a free slot.
    assign occupancy = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue     = (state_q == RUN) & ~halt_req & ~redirect_valid & (occupancy < 3'd2);

    assign redirect_target = redirect_pc & ~XLEN'(3);

    always_comb begin
        state_d = state_q;
        if (!redirect_valid) begin
            case (state_q)
                IDLE:    if (start)    state_d = RUN;
                RUN:     if (halt_req) state_d = HALTED;
                HALTED:  if (start)    state_d = RUN;
                default:               state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (redirect_valid) pc_q <= redirect_target;
            else if (issue)     pc_q <= pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (issue) inflight_pc_q <= pc_q;
    end

    assign push_entry.instr = imem_rdata;
    assign push_entry.pc    = inflight_pc_q;

    smol_fetch_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (push_entry),
        .head  (fifo_head),
        .count (fifo_count)
    );

    assign imem_addr = pc_q[ADDR_WIDTH+1:0];
    assign out_valid = (fifo_count != 2'd0);
    assign out_instr = out_valid ? fifo_head.instr : '0;
    assign out_pc    = out_valid ? fifo_head.pc : '0;
    assign busy      = inflight_q | (fifo_count != 2'd0);

endmodule

// File: tb/tb_smol_fetch_ctrl.sv
// Bench for smol_fetch_ctrl: directed scenarios plus a randomized phase, with every
// accepted beat compared to a sequential-PC reference model of the fetch stream.
module tb_smol_fetch_ctrl;
    import smol_pkg::*;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n, start, halt_req, redirect_valid, out_ready;
    logic [31:0]   redirect_pc;
    logic [AW+1:0] imem_addr, imem_addr2;
    logic [31:0]   imem_rdata, imem_rdata2;
    logic          out_valid, out_valid2, busy, busy2;
    logic [31:0]   out_instr, out_pc, out_instr2, out_pc2;

    int            total = 0;
    int            bad = 0;
    logic [31:0]   exp_pc;
    logic [31:0]   held_pc, held_instr;
    logic [AW+1:0] held_addr;
    logic [31:0]   e2_pc [3];
    logic [31:0]   e2_in [3];

    always #5 clk = ~clk;

    // ROM content: word i holds i+1.
    function automatic logic [31:0] rom_word(input logic [AW+1:0] a);
        return 32'(a[AW+1:2]) + 32'd1;
    endfunction

    always @(posedge clk) begin
        imem_rdata  <= rom_word(imem_addr);
        imem_rdata2 <= rom_word(imem_addr2);
    end

    smol_fetch_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .busy(busy)
    );

    smol_fetch_ctrl #(.ADDR_WIDTH(AW), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_instr(out_instr2), .out_pc(out_pc2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: score any beat accepted at the coming edge, advance the model,
    // then step to 1ns past the edge.
    task automatic cyc();
        if (out_valid && out_ready) begin
            check("beat_pc", 64'(out_pc), 64'(exp_pc));
            check("beat_instr", 64'(out_instr), 64'(rom_word(exp_pc[AW+1:0])));
        end
        if (!rst_n)              exp_pc = 32'h0;
        else if (redirect_valid) exp_pc = redirect_pc & ~32'd3;
        else if (out_valid && out_ready) exp_pc = exp_pc + 32'd4;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; out_ready = 1'b1; exp_pc = 32'h0;
        e2_pc[0] = 32'hFFFF_FFF8; e2_pc[1] = 32'hFFFF_FFFC; e2_pc[2] = 32'h0000_0000;
        e2_in[0] = 32'h3FF;       e2_in[1] = 32'h400;       e2_in[2] = 32'h1;

        // Reset state
        cyc(); cyc();
        rst_n = 1'b1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_addr2", 64'(imem_addr2), 64'hFF8);

        // 1: start, latency of three cycles, then one beat per cycle
        start = 1'b1; cyc(); start = 1'b0;
        check("lat_c1", 64'(out_valid), 64'd0);
        cyc();
        check("lat_c2", 64'(out_valid), 64'd0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_pc", 64'(out_pc), 64'(4 * k));
            check("stream_instr", 64'(out_instr), 64'(k + 1));
            cyc();
        end

        // 2: back-pressure for five cycles
        out_ready = 1'b0;
        held_pc = out_pc; held_instr = out_instr;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_pc", 64'(out_pc), 64'(held_pc));
            check("stall_instr", 64'(out_instr), 64'(held_instr));
        end
        check("stall_count", 64'(dut.u_fifo.count), 64'd2);
        held_addr = imem_addr;
        cyc();
        check("stall_no_issue", 64'(imem_addr), 64'(held_addr));
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) cyc();

        // 3: redirect with a full FIFO and a pop in the same cycle
        out_ready = 1'b0;
        cyc(); cyc(); cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; out_ready = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        check("redir_flush_c1", 64'(out_valid), 64'd0);
        cyc();
        check("redir_flush_c2", 64'(out_valid), 64'd0);
        cyc();
        check("redir_valid", 64'(out_valid), 64'd1);
        check("redir_pc", 64'(out_pc), 64'h100);
        check("redir_instr", 64'(out_instr), 64'h41);
        for (int k = 0; k < 4; k++) cyc();

        // 4: halt drains and stops issuing, start resumes sequentially
        halt_req = 1'b1; cyc(); halt_req = 1'b0;
        held_addr = imem_addr;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("halt_no_issue", 64'(imem_addr), 64'(held_addr));
        end
        check("halt_busy", 64'(busy), 64'd0);
        check("halt_valid", 64'(out_valid), 64'd0);
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        check("resume_valid", 64'(out_valid), 64'd1);
        check("resume_pc", 64'(out_pc), 64'(exp_pc));
        for (int k = 0; k < 3; k++) cyc();

        // Randomized traffic: back-pressure, redirects, start/halt pulses
        for (int n = 0; n < 400; n++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 31) == 0);
            redirect_pc    = $urandom;
            start          = ($urandom_range(0, 15) == 0);
            halt_req       = ($urandom_range(0, 23) == 0);
            cyc();
        end
        redirect_valid = 1'b0; halt_req = 1'b0; out_ready = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 0; k < 6; k++) cyc();

        // 5: PC wrap from a high reset PC
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        for (int k = 0; k < 3; k++) begin
            check("wrap_valid", 64'(out_valid2), 64'd1);
            check("wrap_pc", 64'(out_pc2), 64'(e2_pc[k]));
            check("wrap_instr", 64'(out_instr2), 64'(e2_in[k]));
            cyc();
        end

        // 6: reset with the FIFO full
        out_ready = 1'b0;
        cyc(); cyc(); cyc();
        check("full_before_rst", 64'(dut.u_fifo.count), 64'd2);
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_pc", 64'(out_pc), 64'd0);
        check("mid_rst_instr", 64'(out_instr), 64'd0);
        check("mid_rst_addr", 64'(imem_addr), 64'd0);
        check("mid_rst_count", 64'(dut.u_fifo.count), 64'd0);
        out_ready = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_pc", 64'(out_pc), 64'd0);
        check("post_rst_instr", 64'(out_instr), 64'd1);
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
